div_unit: RTL and testbench

//  Multi-cycle 32/32 radix-2 restoring divider for DIV/DIVU, driven by the EX stage.

---
 rtl/div_unit_pkg.sv | 35 +++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings, bus widths,
// handshake levels and the sign fix-up helper applied to the unsigned core result.
// Imported by div_unit; no ports.
package div_unit_pkg;

    localparam int          REG_W        = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RST_ENABLE   = 1'b1;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BYZERO  = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    // The core divides magnitudes; signs are re-applied here.
    // Flags are already gated with the signed-op bit at acceptance.
    function automatic logic [63:0] sign_fixup(input logic        neg_quo,
                                               input logic        neg_rem,
                                               input logic [31:0] rem,
                                               input logic [31:0] quo);
        logic [31:0] q;
        logic [31:0] r;
        q = neg_quo ? (ZERO_WORD - quo) : quo;
        r = neg_rem ? (ZERO_WORD - rem) : rem;
        return {r, q};
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle 32/32 radix-2 restoring divider for DIV/DIVU (EX stage).
// Ports: clk, rst (sync, active-high), signed_div_i, opdata1_i/opdata2_i (sampled
//   at acceptance), start_i (held until ready_o), annul_i (flush), result_o
//   {rem,quo}, ready_o. Latency 33 cycles, 2 for divide-by-zero.
// Optional DIV_EARLY_OUT_EN: |op1| < |op2| finishes through the short BYZERO path.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [REG_W-1:0]     opdata1_i,
    input  logic [REG_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*REG_W-1:0]   result_o,
    output logic                 ready_o
);

    div_state_t        state;
    div_state_t        state_nxt;
    logic [5:0]        cnt;
    logic [63:0]       work;        // {partial remainder, quotient/dividend bits}
    logic [31:0]       divisor;     // |op2|
    logic              neg_quo;
    logic              neg_rem;

    logic              op1_neg;
    logic              op2_neg;
    logic [31:0]       abs1;
    logic [31:0]       abs2;
    logic              early;

    logic [32:0]       part;
    logic              borrow;
    logic [31:0]       diff;
    logic [63:0]       step_work;

    logic [63:0]       result_nxt;
    logic              ready_nxt;

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign abs1    = op1_neg ? (ZERO_WORD - opdata1_i) : opdata1_i;
    assign abs2    = op2_neg ? (ZERO_WORD - opdata2_i) : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early = (abs1 < abs2);
`else
    assign early = 1'b0;
`endif

    // One restoring step: the shifted remainder is 33 bits wide; when it is
    // >= divisor the true difference is below 2^32, so a 32-bit subtract is exact.
    assign part      = work[63:31];
    assign borrow    = part < {1'b0, divisor};
    assign diff      = part[31:0] - divisor;
    assign step_work = borrow ? {work[62:0], 1'b0}
                              : {diff, work[30:0], 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state <= DIV_FREE;
        else                   state <= state_nxt;
    end

    // Next-state logic; annul overrides everything
    always_comb begin
        state_nxt = state;
        if (annul_i) begin
            state_nxt = DIV_FREE;
        end else begin
            case (state)
                DIV_FREE:   if (start_i == DIV_START)
                                state_nxt = ((opdata2_i == ZERO_WORD) || early) ? DIV_BYZERO : DIV_ON;
                DIV_BYZERO: state_nxt = DIV_END;
                DIV_ON:     if (cnt == 6'd31) state_nxt = DIV_END;
                DIV_END:    if (start_i == DIV_STOP) state_nxt = DIV_FREE;
                default:    state_nxt = DIV_FREE;
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        result_nxt = result_o;
        ready_nxt  = ready_o;
        if (annul_i) begin
            result_nxt = '0;
            ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
                // work holds 0 for x/0, or {|op1|, 0} for early-out
                DIV_BYZERO: begin
                    result_nxt = sign_fixup(neg_quo, neg_rem, work[63:32], work[31:0]);
                    ready_nxt  = DIV_RESULT_READY;
                end
                DIV_ON: if (cnt == 6'd31) begin
                    result_nxt = sign_fixup(neg_quo, neg_rem, step_work[63:32], step_work[31:0]);
                    ready_nxt  = DIV_RESULT_READY;
                end
                DIV_END: if (start_i == DIV_STOP) begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
                default: begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    // Datapath: operand capture and iteration
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (annul_i) begin
            cnt <= '0;
        end else begin
            case (state)
                DIV_FREE: if (start_i == DIV_START) begin
                    cnt     <= '0;
                    divisor <= abs2;
                    neg_quo <= op1_neg ^ op2_neg;
                    neg_rem <= op1_neg;
                    if (opdata2_i == ZERO_WORD) work <= '0;
                    else if (early)             work <= {abs1, ZERO_WORD};
                    else                        work <= {ZERO_WORD, abs1};
                end
                DIV_ON: begin
                    work <= step_work;
                    cnt  <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model built on the simulator's own arithmetic
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] ab;
        aa = (sgn && a[31]) ? -a : a;
        ab = (sgn && b[31]) ? -b : b;
        if (b == 32'h0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (aa < ab) return 2;
`endif
        if (aa == ab) return 33;   // keeps aa/ab in use in both builds
        return 33;
    endfunction

    // Called just after a rising edge: this cycle is cycle 0
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res = exp;
        e.lat = latency(sgn, a, b);
        sb.push_back(e);
    endtask

    task automatic finish_op(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (ready_o) break;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: result with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, "_ready"},   {63'h0, ready_o}, 64'h1);
            check({name, "_latency"}, 64'(n), 64'(e.lat));
            check({name, "_result"},  result_o, e.res);
        end
    endtask

    task automatic release_op(input string name);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop"}, {ready_o, result_o[62:0]}, 64'h0);
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        logic [63:0] held;
        start_op(sgn, a, b, exp);
        finish_op(name);
        held = result_o;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        repeat (2) begin
            @(posedge clk); #1;
            check({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, held[62:0]});
        end
        release_op(name);
    endtask

    initial begin
        logic saw_ready;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          64'h0};
        vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          64'h0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}};
        vecs[6]  = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0}};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,         {32'hFFFF_FFFD, 32'd0}};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1}};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}};
        vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ready_o, result_o[62:0]}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
            run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
        end

        // Annul in cycle 10, restart in cycle 12
        saw_ready = 1'b0;
        start_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
        void'(sb.pop_back());
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            saw_ready |= ready_o;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        saw_ready |= ready_o;
        check("annul_outputs", {ready_o, result_o[62:0]}, 64'h0);
        @(posedge clk); #1;
        saw_ready |= ready_o;
        check("annul_no_ready", {63'h0, saw_ready}, 64'h0);
        run_op("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

        // Reset mid-ON with start held, then a fresh operation
        start_op(1'b0, 32'd12345, 32'd17, {32'd3, 32'd726});
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_on", {ready_o, result_o[62:0]}, 64'h0);
        rst = 1'b0;
        finish_op("after_rst");
        // Reset while in END
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_end", {ready_o, result_o[62:0]}, 64'h0);
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", {ready_o, result_o[62:0]}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
